// File: rtl/sync_fifo_flags.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR      = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDR-1:0] LAST_PTR = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]   DEPTH_C  = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR:0]   AF_C     = (ADDR + 1)'(AF_THRESH);
  localparam logic [ADDR:0]   AE_C     = (ADDR + 1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr;
  logic [ADDR-1:0]  rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  // wr_en/rd_en are requests sampled at the rising edge; an operation takes effect only
  // when accepted (rd_acc/wr_acc), decided from pre-edge state. A full FIFO still accepts
  // a write if a read is accepted in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  function automatic logic [ADDR-1:0] ptr_inc(input logic [ADDR-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error in the same cycle as clr_err leaves the flag set.
      overflow  <= (wr_en && !wr_acc) || (overflow && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [WIDTH-1:0] hold_q;

  // Remembers the head word so data_out keeps showing it once the FIFO drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        hold_q <= '0;
    else if (!empty) hold_q <= mem[rd_ptr];
  end

  assign data_out = empty ? hold_q : mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr];
  end
`endif

endmodule
